// File: rtl/photonic_switch_pkg.sv
// ---------------------------------------------------------------------------
// photonic_switch_pkg
// Shared widths, divider limits and decoder constants for the photonic
// vernier switch, plus the W clamp helper used when a new code is loaded.
// ---------------------------------------------------------------------------
package photonic_switch_pkg;

   localparam int unsigned W_WIDTH  = 13;   // requested delay code width
   localparam int unsigned V_WIDTH  = 7;    // decoded value / edge counter width
   localparam int unsigned CNT_W    = 5;    // divider counter width

   localparam int unsigned DIV8_MAX = 24;   // 200 MHz / 25 -> 8 MHz
   localparam int unsigned DIV1_MAX = 7;    // 8 MHz / 8   -> 1 MHz
   localparam int unsigned MODULUS  = 81;   // vernier modulus (clkB cycles)
   localparam int unsigned W_MAX    = 6479; // largest meaningful code: 79*81+80

   typedef logic [W_WIDTH-1:0] wcode_t;
   typedef logic [V_WIDTH-1:0] val_t;
   typedef logic [CNT_W-1:0]   cnt_t;

   localparam wcode_t W_MAX_C = wcode_t'(W_MAX);
   localparam wcode_t MOD_C   = wcode_t'(MODULUS);
   localparam val_t   CNT_SAT = '1;          // edge counters stick at 127

   function automatic wcode_t clamp_w(input wcode_t w);
      return (w > W_MAX_C) ? W_MAX_C : w;
   endfunction

endpackage

// File: rtl/photonic_switch_wrap_counter.sv
// ---------------------------------------------------------------------------
// wrap_counter
// Counts 0..MAX and wraps to 0, advancing only on cycles where en_i is high.
// Ports:
//   clk    - core clock
//   rst_n  - asynchronous active-low reset (count cleared to 0)
//   en_i   - advance enable
//   cnt_o  - current count
// ---------------------------------------------------------------------------
module wrap_counter #(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned MAX   = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   output logic [WIDTH-1:0] cnt_o
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i) cnt_d = (cnt_q == MAX_C) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/photonic_switch_top.sv
// ---------------------------------------------------------------------------
// photonic_switch_top
// Vernier PWM generator. A load captures delay code W (clamped to 6479) and a
// serial divider splits it into A = W/81 and B = W%81, one subtraction per
// enabled cycle. Every 1 MHz frame tick (with a valid decode) re-arms two
// edge counters: PWMset fires on clkA edge number A (0-based) of the frame,
// PWMreset on clkB edge number B. clkA/clkB are asynchronous tones that are
// synchronized and edge-detected as plain data.
// Ports:
//   clk, reset (async active-low), en (global freeze when low), load, W
//   clkA, clkB          - reference tones (<= clk/2.4)
//   PWMset, PWMreset    - one-cycle pulses, at most one each per frame
//   signal, signal_b    - set at the matching edge, cleared by the frame tick
//   A_val, B_val, decoderDone - decode result
//   c1, c2, cA, cB, en_8MHz, en_1MHz - debug taps
// Build option: define PSW_DEBUG_EN to drive the debug taps with live values;
// otherwise they are tied to 0.
// ---------------------------------------------------------------------------
module photonic_switch_top
   import photonic_switch_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               load,
   input  logic               clkA,
   input  logic               clkB,
   input  logic [W_WIDTH-1:0] W,
   output logic               PWMset,
   output logic               PWMreset,
   output logic               signal,
   output logic               signal_b,
   output logic [V_WIDTH-1:0] A_val,
   output logic [V_WIDTH-1:0] B_val,
   output logic               decoderDone,
   output logic [CNT_W-1:0]   c1,
   output logic [CNT_W-1:0]   c2,
   output logic [V_WIDTH-1:0] cA,
   output logic [V_WIDTH-1:0] cB,
   output logic               en_8MHz,
   output logic               en_1MHz
);

   // ---------------- frame dividers: 200 MHz -> 8 MHz -> 1 MHz -------------
   cnt_t c1_w, c2_w;
   logic en8_w, en1_w;

   wrap_counter #(.WIDTH(CNT_W), .MAX(DIV8_MAX)) u_div8 (
      .clk   (clk),
      .rst_n (reset),
      .en_i  (en),
      .cnt_o (c1_w)
   );

   assign en8_w = en & (c1_w == cnt_t'(DIV8_MAX));

   wrap_counter #(.WIDTH(CNT_W), .MAX(DIV1_MAX)) u_div1 (
      .clk   (clk),
      .rst_n (reset),
      .en_i  (en8_w),
      .cnt_o (c2_w)
   );

   assign en1_w = en8_w & (c2_w == cnt_t'(DIV1_MAX));

   // ---------------- serial divide-by-81 decoder ---------------------------
   wcode_t rem_q, rem_d;
   val_t   quo_q, quo_d;
   val_t   aval_q, aval_d, bval_q, bval_d;
   logic   busy_q, busy_d, done_q, done_d;

   always_comb begin
      rem_d  = rem_q;
      quo_d  = quo_q;
      aval_d = aval_q;
      bval_d = bval_q;
      busy_d = busy_q;
      done_d = done_q;
      if (en) begin
         if (load) begin
            // a load always wins, so a load mid-decode restarts it
            rem_d  = clamp_w(W);
            quo_d  = '0;
            busy_d = 1'b1;
            done_d = 1'b0;
         end else if (busy_q) begin
            if (rem_q >= MOD_C) begin
               rem_d = rem_q - MOD_C;
               quo_d = quo_q + 1'b1;
            end else begin
               aval_d = quo_q;
               bval_d = val_t'(rem_q);   // rem < 81 here, fits in 7 bits
               busy_d = 1'b0;
               done_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rem_q  <= '0;
         quo_q  <= '0;
         aval_q <= '0;
         bval_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         aval_q <= aval_d;
         bval_q <= bval_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   // ---------------- tone synchronizers + rising-edge detect ---------------
   // bits [1:0] are the two-flop synchronizer, bit [2] the edge-detect history.
   // These run regardless of en so the pipeline is never stale on resume.
   logic [2:0] sa_q, sb_q;
   logic [1:0] rise;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sa_q <= '0;
         sb_q <= '0;
      end else begin
         sa_q <= {sa_q[1:0], clkA};
         sb_q <= {sb_q[1:0], clkB};
      end
   end

   assign rise = {sb_q[1] & ~sb_q[2], sa_q[1] & ~sa_q[2]};

   // ---------------- per-channel frame logic (0 = clkA/set, 1 = clkB/reset)
   logic                    tick;
   logic [1:0][V_WIDTH-1:0] tgt;
   logic [1:0][V_WIDTH-1:0] cnt_q, cnt_d;
   logic [1:0]              armed_q, armed_d;
   logic [1:0]              sig_q, sig_d;
   logic [1:0]              pls_q, pls_d;

   assign tick = en1_w & done_q;     // frames never arm without a valid decode
   assign tgt  = {bval_q, aval_q};

   always_comb begin
      cnt_d   = cnt_q;
      armed_d = armed_q;
      sig_d   = sig_q;
      pls_d   = pls_q;
      for (int i = 0; i < 2; i++) begin
         if (en) begin
            pls_d[i] = 1'b0;
            if (tick) begin
               armed_d[i] = 1'b1;
               sig_d[i]   = 1'b0;
               cnt_d[i]   = '0;
               // a coincident edge is edge 0 of the new frame
               if (rise[i]) begin
                  if (tgt[i] == '0) begin
                     sig_d[i] = 1'b1;
                     pls_d[i] = 1'b1;
                  end
                  cnt_d[i] = val_t'(1);
               end
            end else if (rise[i]) begin
               // sig_q doubles as the fired flag: one pulse per frame
               if (armed_q[i] && !sig_q[i] && (cnt_q[i] == tgt[i])) begin
                  sig_d[i] = 1'b1;
                  pls_d[i] = 1'b1;
               end
               if (cnt_q[i] != CNT_SAT) cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q   <= '0;
         armed_q <= '0;
         sig_q   <= '0;
         pls_q   <= '0;
      end else begin
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
         sig_q   <= sig_d;
         pls_q   <= pls_d;
      end
   end

   // ---------------- outputs ----------------------------------------------
   assign PWMset      = pls_q[0];
   assign PWMreset    = pls_q[1];
   assign signal      = sig_q[0];
   assign signal_b    = sig_q[1];
   assign A_val       = aval_q;
   assign B_val       = bval_q;
   assign decoderDone = done_q;

`ifdef PSW_DEBUG_EN
   assign c1      = c1_w;
   assign c2      = c2_w;
   assign cA      = cnt_q[0];
   assign cB      = cnt_q[1];
   assign en_8MHz = en8_w;
   assign en_1MHz = en1_w;
`else
   assign c1      = '0;
   assign c2      = '0;
   assign cA      = '0;
   assign cB      = '0;
   assign en_8MHz = 1'b0;
   assign en_1MHz = 1'b0;
`endif

endmodule

// File: tb/tb_photonic_switch_top.sv
// ---------------------------------------------------------------------------
// tb_photonic_switch_top
// Directed bench for photonic_switch_top with a cycle-level reference model.
// The model tracks enabled-cycle count n (c1 = n%25, c2 = n/25%8), the decode
// result as W/81, W%81 with a countdown of W/81+1 enabled cycles, and each
// frame as "edge number k since the tick". Tones are resampled at the clk
// falling edge so DUT and model see identical data.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_photonic_switch_top;

   logic        clk = 1'b0, reset = 1'b0, en = 1'b0, load = 1'b0;
   logic        clkA = 1'b0, clkB = 1'b0;
   logic [12:0] W = '0;
   logic        PWMset, PWMreset, signal, signal_b, decoderDone;
   logic        en_8MHz, en_1MHz;
   logic [6:0]  A_val, B_val, cA, cB;
   logic [4:0]  c1, c2;

   int errors = 0;
   int checks = 0;

   photonic_switch_top dut (
      .clk(clk), .reset(reset), .en(en), .load(load), .clkA(clkA), .clkB(clkB),
      .W(W), .PWMset(PWMset), .PWMreset(PWMreset), .signal(signal),
      .signal_b(signal_b), .A_val(A_val), .B_val(B_val),
      .decoderDone(decoderDone), .c1(c1), .c2(c2), .cA(cA), .cB(cB),
      .en_8MHz(en_8MHz), .en_1MHz(en_1MHz)
   );

   // 200 MHz core clock, 80 MHz / 81 MHz tones
   always #2.5 clk = ~clk;
   logic toneA = 1'b0, toneB = 1'b0;
   initial begin #0.1; forever #6.25  toneA = ~toneA; end
   initial begin #0.2; forever #6.173 toneB = ~toneB; end
   initial forever begin
      @(negedge clk);
      clkA = toneA;
      clkB = toneB;
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model --------------------------------------
   int   m_n, m_A, m_B, m_rA, m_rB, m_wait;
   bit   m_done, m_pend;
   bit [2:0] m_ha, m_hb;          // tone samples from the last three edges
   int   m_k[2];
   bit   m_armed[2], m_sig[2], m_pls[2];

   task automatic model_clear();
      m_n = 0; m_A = 0; m_B = 0; m_rA = 0; m_rB = 0; m_wait = 0;
      m_done = 0; m_pend = 0; m_ha = '0; m_hb = '0;
      for (int i = 0; i < 2; i++) begin
         m_k[i] = 0; m_armed[i] = 0; m_sig[i] = 0; m_pls[i] = 0;
      end
   endtask

   task automatic model_step();
      bit rise[2];
      bit tick;
      int tgt[2];
      int wc;
      // synchronized edge seen now = sample two edges ago high, three ago low
      rise[0] = m_ha[1] & ~m_ha[2];
      rise[1] = m_hb[1] & ~m_hb[2];
      m_ha = {m_ha[1:0], clkA};
      m_hb = {m_hb[1:0], clkB};
      if (!en) return;
      tick   = (m_n % 200 == 199) && m_done;
      tgt[0] = m_A;
      tgt[1] = m_B;
      for (int i = 0; i < 2; i++) begin
         m_pls[i] = 0;
         if (tick) begin
            m_armed[i] = 1; m_sig[i] = 0; m_k[i] = 0;
         end
         if (rise[i]) begin
            if (m_armed[i] && !m_sig[i] && ((m_k[i] > 127) ? 127 : m_k[i]) == tgt[i]) begin
               m_sig[i] = 1; m_pls[i] = 1;
            end
            m_k[i]++;
         end
      end
      if (load) begin
         wc = (W > 13'd6479) ? 6479 : int'(W);
         m_rA = wc / 81; m_rB = wc % 81;
         m_wait = m_rA + 1; m_pend = 1; m_done = 0;
      end else if (m_pend) begin
         m_wait--;
         if (m_wait == 0) begin
            m_pend = 0; m_done = 1; m_A = m_rA; m_B = m_rB;
         end
      end
      m_n++;
   endtask

   // single compare process: every cycle, 1 ns after the rising edge
   initial begin
      model_clear();
      forever begin
         @(posedge clk);
         if (!reset) model_clear();
         else        model_step();
         #1;
         chk("c1",          dut.c1_w,      m_n % 25);
         chk("c2",          dut.c2_w,      (m_n / 25) % 8);
         chk("en_8MHz",     dut.en8_w,     int'(en && (m_n % 25 == 24)));
         chk("en_1MHz",     dut.en1_w,     int'(en && (m_n % 200 == 199)));
         chk("cA",          dut.cnt_q[0],  (m_k[0] > 127) ? 127 : m_k[0]);
         chk("cB",          dut.cnt_q[1],  (m_k[1] > 127) ? 127 : m_k[1]);
         chk("PWMset",      PWMset,        m_pls[0]);
         chk("PWMreset",    PWMreset,      m_pls[1]);
         chk("signal",      signal,        m_sig[0]);
         chk("signal_b",    signal_b,      m_sig[1]);
         chk("A_val",       A_val,         m_A);
         chk("B_val",       B_val,         m_B);
         chk("decoderDone", decoderDone,   m_done);
`ifdef PSW_DEBUG_EN
         chk("c1_port",     c1,            m_n % 25);
         chk("cA_port",     cA,            (m_k[0] > 127) ? 127 : m_k[0]);
         chk("en1_port",    en_1MHz,       int'(en && (m_n % 200 == 199)));
`else
         chk("dbg_ports",   int'({c1, c2, cA, cB, en_8MHz, en_1MHz}), 0);
`endif
      end
   end

   // ---------------- directed stimulus -------------------------------------
   task automatic run_load(input int w, output int lat);
      @(negedge clk);
      W = 13'(w);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      lat = 0;
      while (!decoderDone && lat < 300) begin
         @(negedge clk);
         lat++;
      end
   endtask

   int tw[7]   = '{2, 3000, 1000, 500, 6479, 6480, 8191};
   int ta[7]   = '{0,   37,   12,   6,   79,   79,   79};
   int tb_[7]  = '{2,    3,   28,  14,   80,   80,   80};
   int tl[7]   = '{1,   38,   13,   7,   80,   80,   80};

   initial begin
      int lat, n8, n1, first8, setr, seth, rstr, rsth, set_idx, wait_cnt;
      logic prev_s, prev_r;

      // reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_A_val",  A_val, 0);
      chk("rst_done",   decoderDone, 0);
      chk("rst_pulses", int'({PWMset, PWMreset, signal, signal_b}), 0);
      chk("rst_c1",     dut.c1_w, 0);
      @(negedge clk);
      reset = 1'b1;

      // dividers: 1000 enabled cycles
      en = 1'b1;
      n8 = 0; n1 = 0; first8 = -1;
      for (int j = 1; j <= 1000; j++) begin
         @(negedge clk);
         if (dut.en8_w) begin
            n8++;
            if (first8 < 0) first8 = j;
         end
         if (dut.en1_w) n1++;
      end
      chk("div8_count", n8, 40);
      chk("div1_count", n1, 5);
      chk("div8_first", first8, 24);
      chk("idle_no_frame", int'({signal, signal_b, decoderDone}), 0);

      // decode table
      for (int t = 0; t < 7; t++) begin
         run_load(tw[t], lat);
         chk($sformatf("lat_W%0d", tw[t]), lat, tl[t]);
         chk($sformatf("A_W%0d", tw[t]), A_val, ta[t]);
         chk($sformatf("B_W%0d", tw[t]), B_val, tb_[t]);
      end

      // load during a decode restarts it
      @(negedge clk); W = 13'd3000; load = 1'b1;
      @(negedge clk); load = 1'b0;
      repeat (5) @(negedge clk);
      run_load(500, lat);
      chk("restart_lat", lat, 7);
      chk("restart_A",   A_val, 6);
      chk("restart_B",   B_val, 14);

      // pulses with W=2: align to a frame tick, then watch three frames
      run_load(2, lat);
      wait_cnt = 0;
      while (!dut.en1_w && wait_cnt < 400) begin
         @(negedge clk);
         wait_cnt++;
      end
      chk("tick_found", int'(dut.en1_w), 1);
      setr = 0; seth = 0; rstr = 0; rsth = 0; set_idx = -1;
      prev_s = PWMset; prev_r = PWMreset;
      for (int j = 1; j <= 600; j++) begin
         @(negedge clk);
         if (PWMset)  seth++;
         if (PWMreset) rsth++;
         if (PWMset && !prev_s) begin
            setr++;
            if (set_idx < 0) set_idx = j;
         end
         if (PWMreset && !prev_r) rstr++;
         prev_s = PWMset; prev_r = PWMreset;
      end
      chk("set_per_frame",   setr, 3);
      chk("set_width",       seth, 3);
      chk("reset_per_frame", rstr, 3);
      chk("reset_width",     rsth, 3);
      chk("set_first_edge",  int'(set_idx >= 1 && set_idx <= 4), 1);

      // en low for 50 cycles in the middle of a decode
      @(negedge clk); W = 13'd3000; load = 1'b1;
      @(negedge clk); load = 1'b0;
      lat = 0;
      while (!decoderDone && lat < 400) begin
         @(negedge clk);
         lat++;
         if (lat == 10) en = 1'b0;
         if (lat == 60) en = 1'b1;
      end
      en = 1'b1;
      chk("freeze_lat", lat, 88);
      chk("freeze_A",   A_val, 37);
      chk("freeze_B",   B_val, 3);
      repeat (450) @(negedge clk);   // let frames with A=37 run

      // reset in the middle of a decode
      @(negedge clk); W = 13'd6000; load = 1'b1;
      @(negedge clk); load = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst_vals", int'({A_val, B_val}), 0);
      chk("midrst_flags", int'({decoderDone, signal, signal_b, PWMset, PWMreset}), 0);
      chk("midrst_cA", dut.cnt_q[0], 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (300) @(negedge clk);
      chk("post_rst_idle", int'({decoderDone, signal, signal_b, A_val}), 0);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/photonic_switch_top.md
PHOTONIC_SWITCH_TOP -- requirements
Module: photonic_switch_top

Interface
REQ-001 SHALL have port clk, input, 1 bit: single core clock, 200 MHz nominal; all logic rising-edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port en, input, 1 bit: global enable; low freezes all counters, decoder and output state.
REQ-004 SHALL have port load, input, 1 bit: sampled high captures W and restarts the decoder.
REQ-005 SHALL have ports clkA and clkB, input, 1 bit each: asynchronous reference tones (80 MHz / 81 MHz), treated as data.
REQ-006 SHALL have port W, input, 13 bits: requested vernier delay code, 0..6479.
REQ-007 SHALL have ports PWMset and PWMreset, output, 1 bit each: one-cycle pulses.
REQ-008 SHALL have ports signal and signal_b, output, 1 bit each: per-frame level flags.
REQ-009 SHALL have ports A_val and B_val, output, 7 bits each, and decoderDone, output, 1 bit: decoded result and valid flag.
REQ-010 SHALL have debug output ports c1 and c2 (5 bits each), cA and cB (7 bits each), en_8MHz and en_1MHz (1 bit each).

Function
REQ-011 SHALL run c1 from 0 to 24, then wrap to 0, when en is high; en_8MHz SHALL be high exactly in cycles where c1==24 and en is high.
REQ-012 SHALL advance c2 from 0 to 7, then wrap, on each en_8MHz; en_1MHz SHALL be high exactly when c2==7 and en_8MHz is high, giving one tick per 200 clk cycles.
REQ-013 On load high, SHALL capture Wc = min(W, 6479), clear decoderDone, set quotient to 0 and remainder to Wc.
REQ-014 Each enabled cycle while busy, SHALL act on the remainder: if remainder >= 81, subtract 81 and increment quotient; otherwise set A_val = quotient, B_val = remainder and decoderDone = 1.
REQ-015 Decode latency SHALL be floor(Wc/81)+1 cycles after load; load during an active decode SHALL restart it with the new W.
REQ-016 SHALL pass clkA and clkB through 2-flop synchronizers and detect rising edges; input frequency SHALL be at most clk/2.4.
REQ-017 At each en_1MHz tick with decoderDone high, SHALL clear cA, cB, signal and signal_b and arm the frame.
REQ-018 On each clkA edge event, SHALL test cA: if armed and cA==A_val (pre-increment value), set signal and pulse PWMset for one cycle; then increment cA, saturating at 127.
REQ-019 SHALL handle clkB, cB, B_val, signal_b and PWMreset exactly as REQ-018, independently.
REQ-020 SHALL fire each of PWMset and PWMreset at most once per frame; no frame SHALL arm while decoderDone is low.
REQ-021 If a frame tick and an edge event coincide, the tick SHALL take priority and the edge SHALL count as the first edge of the new frame.

Reset
REQ-022 While reset is low, SHALL hold all registers at 0: c1, c2, cA, cB, A_val, B_val, decoderDone, signal, signal_b, PWMset, PWMreset, captured W, synchronizers.
REQ-023 After reset release, SHALL stay idle until load, with no frames armed.

Configuration
REQ-024 Macro PSW_DEBUG_EN: when defined, c1, c2, cA, cB, en_8MHz and en_1MHz SHALL drive the live internal values.
REQ-025 Without PSW_DEBUG_EN, those debug ports SHALL drive constant 0 and all other behaviour SHALL be unchanged.

Structure
REQ-026 Package photonic_switch_pkg SHALL hold constants DIV8_MAX=24, DIV1_MAX=7, MODULUS=81, W_MAX=6479 and the 13-bit and 7-bit width parameters.
REQ-027 SHALL implement c1 and c2 with one parameterized sub-module, wrap_counter (width, max value, enable input).

Verification
REQ-028 Decode: load with W=2 -> A_val=0, B_val=2 after 1 cycle; W=3000 -> 37/3 after 38 cycles; W=1000 -> 12/28; W=500 -> 6/14.
REQ-029 Saturation: W=6479 and W=6480 -> both give A_val=79, B_val=80, decoderDone after 80 cycles.
REQ-030 Dividers: en high for 1000 cycles -> en_8MHz every 25 cycles, en_1MHz every 200 cycles, c2 sequence 0..7.
REQ-031 Pulses: clkA 12.5 ns and clkB 12.3457 ns with W=2 -> per frame, PWMset on 1st clkA edge, PWMreset on 3rd clkB edge, each one cycle wide, once per frame.
REQ-032 Reset mid-decode and en low: reset low during decode -> all outputs 0 immediately; en low for 50 cycles -> c1, cA and decode progress frozen, then resume.
